// File: rtl/lsu_hs.sv
// Multi-cycle load/store unit with valid/ready handshakes on the core and memory sides.
// One transaction in flight; handles byte lanes, extension, misalignment and memory errors.
module lsu_hs #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_op,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic            ready_q;
    logic [2:0]      op_q;
    logic [OW-1:0]   off_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [NB-1:0]   wmask_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;

    logic            accept;
    logic [OW-1:0]   off;
    logic            illegal;
    logic            misal;
    logic            bad;
    logic [NB-1:0]   base;
    logic [NB-1:0]   wmask_n;
    logic [XLEN-1:0] wdata_n;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] ext;
    logic            msb;
    int              width;

    assign accept = req_valid && ready_q;
    assign off    = req_addr[OW-1:0];

    always_comb begin
        illegal = (req_op == 3'b111) ||
                  (XLEN == 32 && (req_op == 3'b011 || req_op == 3'b110));
        case (req_op[1:0])
            2'b01:   misal = req_addr[0];
            2'b10:   misal = |req_addr[1:0];
            2'b11:   misal = |req_addr[2:0];
            default: misal = 1'b0;
        endcase
        bad = illegal || misal;
    end

    always_comb begin
        base = '0;
        case (req_op[1:0])
            2'b00:   base[0]   = 1'b1;
            2'b01:   base[1:0] = 2'b11;
            2'b10:   base[3:0] = 4'hF;
            default: base      = '1;
        endcase
        wmask_n = req_write ? (base << off) : '0;
        wdata_n = req_wdata << {off, 3'b000};
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (op_q[1:0])
            2'b00:   begin width = 8;    msb = shifted[7];      end
            2'b01:   begin width = 16;   msb = shifted[15];     end
            2'b10:   begin width = 32;   msb = shifted[31];     end
            default: begin width = XLEN; msb = shifted[XLEN-1]; end
        endcase
        ext = shifted;
        for (int i = 8; i < XLEN; i++) begin
            if (i >= width) ext[i] = ~op_q[2] & msb;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = bad ? RESP : REQ;
            REQ:     if (mem_ready) state_n = WAIT;
            WAIT:    if (mem_rvalid) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            op_q    <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == IDLE);
            if (state == IDLE && accept) begin
                op_q    <= req_op;
                off_q   <= off;
                we_q    <= req_write;
                addr_q  <= {req_addr[AW-1:OW], {OW{1'b0}}};
                wdata_q <= wdata_n;
                wmask_q <= wmask_n;
                rdata_q <= '0;
                err_q   <= bad;
            end
            if (state == WAIT && mem_rvalid) begin
                err_q   <= mem_err;
                rdata_q <= (mem_err || we_q) ? '0 : ext;
            end
        end
    end

    assign req_ready = ready_q;
    assign mem_valid = (state == REQ);
    assign rsp_valid = (state == RESP);
    assign mem_we    = mem_valid & we_q;
    assign mem_addr  = mem_valid ? addr_q : '0;
    assign mem_wdata = mem_valid ? wdata_q : '0;
    assign mem_wmask = mem_valid ? wmask_q : '0;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid & err_q;

endmodule
